// File: rtl/mem_rr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared state encoding, owner encoding and burst defaults for
//                the stim/check round-robin SRAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Grant FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STIM  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  // Encoding of the last_owner bit
  localparam logic OWNER_STIM  = 1'b0;
  localparam logic OWNER_CHECK = 1'b1;

  // Default number of back-to-back transfers one side may take under contention
  localparam int DEFAULT_MAX_BURST = 4;

  // Burst counter increment that sticks at its maximum instead of wrapping
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rr_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rr_arb_if
//  Description : Bundle of the three Avalon-MM style ports around the arbiter:
//                the shared SRAM master port, the stim read-only port and the
//                check write-only port. "master" is the arbiter's view,
//                "slave" is the view of the surrounding environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_rr_arb_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  // Shared SRAM port
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [BE_WIDTH-1:0]   mem_byteenable;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_readdata;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_writedata;
  logic                  mem_waitrequest;

  // Stimulus reader (read-only)
  logic [ADDR_WIDTH-1:0] stim_address;
  logic [BE_WIDTH-1:0]   stim_byteenable;
  logic                  stim_read;
  logic [DATA_WIDTH-1:0] stim_readdata;
  logic                  stim_waitrequest;

  // Result checker (write-only)
  logic [ADDR_WIDTH-1:0] check_address;
  logic [BE_WIDTH-1:0]   check_byteenable;
  logic                  check_write;
  logic [DATA_WIDTH-1:0] check_writedata;
  logic                  check_waitrequest;

  modport master (
    output mem_address, mem_byteenable, mem_read, mem_write, mem_writedata,
    input  mem_readdata, mem_waitrequest,
    input  stim_address, stim_byteenable, stim_read,
    output stim_readdata, stim_waitrequest,
    input  check_address, check_byteenable, check_write, check_writedata,
    output check_waitrequest
  );

  modport slave (
    input  mem_address, mem_byteenable, mem_read, mem_write, mem_writedata,
    output mem_readdata, mem_waitrequest,
    output stim_address, stim_byteenable, stim_read,
    input  stim_readdata, stim_waitrequest,
    output check_address, check_byteenable, check_write, check_writedata,
    input  check_waitrequest
  );

endinterface
`default_nettype wire

// File: rtl/mem_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rr_arb
//  Description : Fair, burst-limited arbiter sharing one SRAM Avalon-MM port
//                between the stim reader and the check writer. Ownership is
//                registered and held across waitrequest stalls; under
//                contention the owner yields after MAX_BURST transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  wire logic     clock,
  input  wire logic     reset_n,
  mem_rr_arb_if.master  bus
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  logic [1:0] state, state_nxt;
  logic [7:0] burst_cnt, burst_cnt_nxt;
  logic       last_owner, last_owner_nxt;

  logic       own_req;
  logic       oth_req;
  logic [1:0] other_state;
  logic       owner_bit;
  logic [7:0] cnt_inc;

  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [BE_WIDTH-1:0]   be_mux;
  logic [DATA_WIDTH-1:0] wdata;

  // Request view relative to the current owner (meaningless in IDLE)
  assign own_req     = (state == CHECK) ? bus.check_write : bus.stim_read;
  assign oth_req     = (state == CHECK) ? bus.stim_read   : bus.check_write;
  assign other_state = (state == CHECK) ? STIM : CHECK;
  assign owner_bit   = (state == CHECK) ? OWNER_CHECK : OWNER_STIM;
  assign cnt_inc     = sat_inc(burst_cnt);

  // State, burst counter and fairness bit registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      burst_cnt  <= 8'd0;
      last_owner <= OWNER_STIM;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Grant decision: hold through stalls, yield after a burst or a dropped request
  always_comb begin
    state_nxt      = state;
    burst_cnt_nxt  = burst_cnt;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        if (bus.stim_read && bus.check_write) begin
          state_nxt = (last_owner == OWNER_STIM) ? CHECK : STIM;
        end else if (bus.stim_read) begin
          state_nxt = STIM;
        end else if (bus.check_write) begin
          state_nxt = CHECK;
        end
      end
      STIM, CHECK: begin
        if (own_req && !bus.mem_waitrequest) begin
          // A transfer completes this cycle
          last_owner_nxt = owner_bit;
          if (oth_req && (!own_req || (cnt_inc >= MAX_BURST_C))) begin
            state_nxt     = other_state;
            burst_cnt_nxt = 8'd0;
          end else if (own_req) begin
            burst_cnt_nxt = cnt_inc;
          end else begin
            state_nxt     = IDLE;
            burst_cnt_nxt = 8'd0;
          end
        end else if (!own_req) begin
          // Request withdrawn without a transfer: hand over or go idle
          state_nxt     = oth_req ? other_state : IDLE;
          burst_cnt_nxt = 8'd0;
        end
        // own_req held with waitrequest: keep everything stable
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Master port mux and requester stalls, driven only by the registered owner
  always_comb begin
    addr_mux              = '0;
    be_mux                = '0;
    bus.mem_read          = 1'b0;
    bus.mem_write         = 1'b0;
    bus.stim_waitrequest  = 1'b1;
    bus.check_waitrequest = 1'b1;
    case (state)
      STIM: begin
        addr_mux             = bus.stim_address;
        be_mux               = bus.stim_byteenable;
        bus.mem_read         = bus.stim_read;
        bus.stim_waitrequest = bus.mem_waitrequest;
      end
      CHECK: begin
        addr_mux              = bus.check_address;
        be_mux                = bus.check_byteenable;
        bus.mem_write         = bus.check_write;
        bus.check_waitrequest = bus.mem_waitrequest;
      end
      default: begin
        addr_mux = '0;
        be_mux   = '0;
      end
    endcase
  end

  assign wdata              = bus.check_writedata;
  assign bus.mem_address    = addr_mux;
  assign bus.mem_byteenable = be_mux;
  assign bus.mem_writedata  = wdata;
  assign bus.stim_readdata  = bus.mem_readdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_rr_arb
//  Description : Scoreboard bench for mem_rr_arb. Stimulus pushes expected
//                SRAM transfers; a negedge monitor pops and compares each
//                transfer the arbiter completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_rr_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_rr_arb_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .BE_WIDTH(2)) bus ();

  mem_rr_arb #(
    .ADDR_WIDTH(20), .DATA_WIDTH(16), .BE_WIDTH(2), .MAX_BURST(4)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic        is_write;
    logic [19:0] addr;
    logic [1:0]  be;
    logic [15:0] data;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t mon_e;
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM read model: one special location, otherwise an address pattern
  function automatic logic [15:0] rd_model(input logic [19:0] a);
    if (a == 20'h00012) return 16'hBEEF;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  assign bus.mem_readdata = rd_model(bus.mem_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic w, input logic [19:0] a, input logic [1:0] be,
                      input logic [15:0] d);
    xfer_t e;
    e.is_write = w; e.addr = a; e.be = be; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed SRAM transfer must match the head of the queue
  always @(negedge clk) begin
    if (rst_n && (bus.mem_read || bus.mem_write) && !bus.mem_waitrequest) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_xfer: got transfer at addr %0h, required none", bus.mem_address);
      end else begin
        mon_e = exp_q.pop_front();
        chk("xfer_kind", {31'd0, bus.mem_write}, {31'd0, mon_e.is_write});
        chk("xfer_addr", {12'd0, bus.mem_address}, {12'd0, mon_e.addr});
        chk("xfer_be", {30'd0, bus.mem_byteenable}, {30'd0, mon_e.be});
        if (mon_e.is_write)
          chk("xfer_wdata", {16'd0, bus.mem_writedata}, {16'd0, mon_e.data});
        else
          chk("xfer_rdata", {16'd0, bus.stim_readdata}, {16'd0, mon_e.data});
      end
    end
  end

  // Avalon-style read master: holds read until accepted, n reads from base
  task automatic drive_stim(input int n, input logic [19:0] base, output int last);
    int i = 0;
    int guard = 0;
    last = 0;
    bus.stim_read = 1'b1;
    bus.stim_address = base;
    bus.stim_byteenable = 2'b11;
    while (i < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if (!bus.stim_waitrequest) begin
        i++;
        last = cyc;
      end
      @(posedge clk);
      #1;
      if (i < n) bus.stim_address = base + 20'(i);
    end
    bus.stim_read = 1'b0;
    if (i < n) begin
      total++; bad++;
      $display("FAIL stim_timeout: got %0d reads required %0d", i, n);
    end
  endtask

  // Avalon-style write master: holds write until accepted, n writes from base
  task automatic drive_check(input int n, input logic [19:0] base, input logic [15:0] dbase,
                             output int last);
    int i = 0;
    int guard = 0;
    last = 0;
    bus.check_write = 1'b1;
    bus.check_address = base;
    bus.check_byteenable = 2'b11;
    bus.check_writedata = dbase;
    while (i < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if (!bus.check_waitrequest) begin
        i++;
        last = cyc;
      end
      @(posedge clk);
      #1;
      if (i < n) begin
        bus.check_address = base + 20'(i);
        bus.check_writedata = dbase + 16'(i);
      end
    end
    bus.check_write = 1'b0;
    if (i < n) begin
      total++; bad++;
      $display("FAIL check_timeout: got %0d writes required %0d", i, n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100us");
    $fatal(1);
  end

  initial begin
    int start;
    int s_last;
    int c_last;

    rst_n = 1'b0;
    bus.mem_waitrequest  = 1'b0;
    bus.stim_read        = 1'b0;
    bus.stim_address     = '0;
    bus.stim_byteenable  = '0;
    bus.check_write      = 1'b0;
    bus.check_address    = '0;
    bus.check_byteenable = '0;
    bus.check_writedata  = '0;

    // Reset, then idle
    tick(); tick();
    @(negedge clk);
    chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_addr", {12'd0, bus.mem_address}, 32'd0);
    chk("rst_be", {30'd0, bus.mem_byteenable}, 32'd0);
    chk("rst_stim_wait", {31'd0, bus.stim_waitrequest}, 32'd1);
    chk("rst_check_wait", {31'd0, bus.check_waitrequest}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("idle_mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk("idle_stim_wait", {31'd0, bus.stim_waitrequest}, 32'd1);
    chk("idle_check_wait", {31'd0, bus.check_waitrequest}, 32'd1);

    // Single stim read, one-cycle arbitration latency
    tick();
    bus.stim_read = 1'b1;
    bus.stim_address = 20'h00012;
    bus.stim_byteenable = 2'b11;
    push(1'b0, 20'h00012, 2'b11, 16'hBEEF);
    @(negedge clk);
    chk("t2_latency_read", {31'd0, bus.mem_read}, 32'd0);
    chk("t2_latency_wait", {31'd0, bus.stim_waitrequest}, 32'd1);
    tick();
    @(negedge clk);
    chk("t2_mem_read", {31'd0, bus.mem_read}, 32'd1);
    chk("t2_addr", {12'd0, bus.mem_address}, 32'h00012);
    chk("t2_stim_wait", {31'd0, bus.stim_waitrequest}, 32'd0);
    chk("t2_rdata", {16'd0, bus.stim_readdata}, 32'h0000BEEF);
    tick();
    bus.stim_read = 1'b0;
    tick(); tick();

    // Contention with last_owner=STIM (CHECK wins), stall hold, early release
    bus.mem_waitrequest = 1'b1;
    bus.check_write = 1'b1;
    bus.check_address = 20'h00345;
    bus.check_byteenable = 2'b01;
    bus.check_writedata = 16'hCAFE;
    bus.stim_read = 1'b1;
    bus.stim_address = 20'h00012;
    bus.stim_byteenable = 2'b11;
    push(1'b1, 20'h00345, 2'b01, 16'hCAFE);
    push(1'b0, 20'h00012, 2'b11, 16'hBEEF);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_write", {31'd0, bus.mem_write}, 32'd1);
      chk("t3_stall_addr", {12'd0, bus.mem_address}, 32'h00345);
      chk("t3_stall_wdata", {16'd0, bus.mem_writedata}, 32'h0000CAFE);
      chk("t3_stall_stim_wait", {31'd0, bus.stim_waitrequest}, 32'd1);
      chk("t3_stall_check_wait", {31'd0, bus.check_waitrequest}, 32'd1);
      tick();
    end
    bus.mem_waitrequest = 1'b0;
    @(negedge clk);
    chk("t3_check_accept", {31'd0, bus.check_waitrequest}, 32'd0);
    tick();
    bus.check_write = 1'b0;
    @(negedge clk);
    chk("t5_drop_write", {31'd0, bus.mem_write}, 32'd0);
    chk("t5_drop_stim_wait", {31'd0, bus.stim_waitrequest}, 32'd1);
    tick();
    @(negedge clk);
    chk("t5_stim_granted", {31'd0, bus.mem_read}, 32'd1);
    chk("t5_stim_wait", {31'd0, bus.stim_waitrequest}, 32'd0);
    tick();
    bus.stim_read = 1'b0;
    tick(); tick();
    chk("t3_queue_empty", exp_q.size(), 32'd0);

    // Burst limit under continuous contention, from reset
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) push(1'b0, 20'h00100 + 20'(i), 2'b11, (16'h0100 + 16'(i)) ^ 16'h5A5A);
    for (int i = 0; i < 4; i++) push(1'b1, 20'h00200 + 20'(i), 2'b11, 16'hD000 + 16'(i));
    for (int i = 4; i < 8; i++) push(1'b0, 20'h00100 + 20'(i), 2'b11, (16'h0100 + 16'(i)) ^ 16'h5A5A);
    for (int i = 4; i < 8; i++) push(1'b1, 20'h00200 + 20'(i), 2'b11, 16'hD000 + 16'(i));
    start = cyc;
    fork
      begin
        drive_stim(8, 20'h00100, s_last);
      end
      begin
        tick();
        drive_check(8, 20'h00200, 16'hD000, c_last);
      end
    join
    chk("t4_stim_last_cycle", 32'(s_last - start), 32'd12);
    chk("t4_check_last_cycle", 32'(c_last - start), 32'd16);
    tick(); tick();
    chk("t4_queue_empty", exp_q.size(), 32'd0);

    // Reset asserted mid-stall abandons the pending read
    bus.stim_read = 1'b1;
    bus.stim_address = 20'h00077;
    bus.stim_byteenable = 2'b11;
    bus.mem_waitrequest = 1'b1;
    tick(); tick();
    #2;
    chk("t6_pre_read", {31'd0, bus.mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_read", {31'd0, bus.mem_read}, 32'd0);
    chk("t6_async_wait", {31'd0, bus.stim_waitrequest}, 32'd1);
    chk("t6_async_addr", {12'd0, bus.mem_address}, 32'd0);
    bus.mem_waitrequest = 1'b0;
    tick();
    rst_n = 1'b1;
    push(1'b0, 20'h00077, 2'b11, 16'h5A2D);
    @(negedge clk);
    chk("t6_release_wait", {31'd0, bus.stim_waitrequest}, 32'd1);
    chk("t6_release_read", {31'd0, bus.mem_read}, 32'd0);
    tick();
    @(negedge clk);
    chk("t6_regrant_read", {31'd0, bus.mem_read}, 32'd1);
    tick();
    bus.stim_read = 1'b0;
    tick(); tick();

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_rr_arb.md
Name: mem_rr_arb

Overview:
- Fair, burst-limited arbiter sharing the single 16-bit SRAM Avalon-MM master port between the stimulus reader (stim, read-only) and the result checker (check, write-only).
- Registered grant FSM holds ownership for the whole duration of a waitrequest stall, so master signals stay stable as Avalon requires.
- Alternates owners on contention after at most MAX_BURST back-to-back transfers, so neither side starves.
- Sits between the stim/check engines and sram_arb.

Parameters:
ADDR_WIDTH, 20, word address width
DATA_WIDTH, 16, data width
BE_WIDTH, DATA_WIDTH/8, byteenable width
MAX_BURST, 4, max consecutive transfers for one owner while the other requests (legal 1..255)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
mem_address  out  ADDR_WIDTH  to sram_arb
mem_byteenable  out  BE_WIDTH  to sram_arb
mem_read  out  1  read strobe
mem_readdata  in  DATA_WIDTH  read data, valid in the cycle mem_read=1 and mem_waitrequest=0
mem_write  out  1  write strobe
mem_writedata  out  DATA_WIDTH  write data
mem_waitrequest  in  1  slave stall
stim_address  in  ADDR_WIDTH  stim read address
stim_byteenable  in  BE_WIDTH  stim byteenable
stim_read  in  1  stim read request
stim_readdata  out  DATA_WIDTH  equals mem_readdata at all times
stim_waitrequest  out  1  stim stall
check_address  in  ADDR_WIDTH  check write address
check_byteenable  in  BE_WIDTH  check byteenable
check_write  in  1  check write request
check_writedata  in  DATA_WIDTH  check write data
check_waitrequest  out  1  check stall

Behaviour:
- Clock and reset: single clock `clock`. `reset_n` is asynchronous and active-low.
- State register: the only sequential elements are `state` (IDLE, STIM, CHECK), an 8-bit `burst_cnt` and a `last_owner` bit. All are cleared to IDLE / 0 / STIM on reset.
- Definitions: xfer = owner's request asserted and mem_waitrequest=0. "other" = the non-owner's request.
- Outputs, combinational from the registered state only:
  - mem_read = (state==STIM) & stim_read
  - mem_write = (state==CHECK) & check_write
  - Address and byteenable mux from the owner. Both are 0 in IDLE.
  - mem_writedata = check_writedata, always.
  - Granted side's waitrequest = mem_waitrequest. Non-granted side's waitrequest = 1.
  - In IDLE, both waitrequests = 1.
- Reset values: mem_read=0, mem_write=0, address=0, byteenable=0, stim_waitrequest=1, check_waitrequest=1.
- IDLE transitions:
  - Only stim_read → STIM.
  - Only check_write → CHECK.
  - Both → the side ≠ last_owner.
  - Neither → stay IDLE.
  - Arbitration latency is exactly 1 cycle: a request seen in cycle N appears on mem_* in cycle N+1.
- Owner state, evaluated each cycle:
  - If mem_waitrequest=1 and owner request is held: stay, no counter change. Ownership never changes mid-stall.
  - On xfer, burst_cnt+1 (saturating at 255), and last_owner ← owner.
  - After the xfer: if other is requesting and (owner request is low or burst_cnt+1 ≥ MAX_BURST), switch to the other state with burst_cnt ← 0. Else if the owner is still requesting, stay. Else go IDLE with burst_cnt ← 0.
  - If the owner request drops with no xfer (illegal under Avalon, tolerated): go to the other state if other is requesting, else IDLE. burst_cnt ← 0 and no transfer is issued.
- Switching costs no idle cycle: the new owner's transfer starts in the cycle after the last xfer.
- MAX_BURST=1 gives strict alternation under contention.
- Simultaneous new requests in IDLE with last_owner=STIM: CHECK wins.
- Reset asserted mid-stall: FSM returns to IDLE immediately and the pending transfer is abandoned. After reset release both requesters see waitrequest=1 until granted.

Decomposition:
- Package mem_arb_pkg holds the state encoding localparams (IDLE=2'd0, STIM=2'd1, CHECK=2'd2) and the default MAX_BURST.
- No sub-module is natural. The FSM, counter and output mux fit one module of about 150 lines.

Test Plan:
1. Reset then idle: reset_n low, all requests 0 → mem_read=0, mem_write=0, mem_address=0, both waitrequests=1 after release.
2. Single stim read: stim_read=1, stim_address=0x00012, mem_waitrequest=0 → mem_read=1 with mem_address=0x00012 one cycle later. stim_waitrequest=0 that cycle. stim_readdata=mem_readdata=0xBEEF.
3. Stall hold: CHECK owns, mem_waitrequest=1 for 5 cycles while stim_read=1 → mem_write, mem_address and mem_writedata stable all 5 cycles. stim_waitrequest=1 throughout.
4. Burst limit: both request continuously, MAX_BURST=4, no stalls, start from reset → 4 stim reads then 4 check writes, repeating. No idle cycles between bursts.
5. Early release: CHECK owns with burst_cnt=1, check_write drops after its xfer, stim_read=1 → STIM is granted the next cycle (burst_cnt=0).
6. Reset mid-stall: STIM owns, mem_waitrequest=1, reset_n pulsed low → mem_read=0 asynchronously, state IDLE, stim_waitrequest=1.
